// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave fronting a flat byte-addressable register bank.
// Independent write (AW/W collect -> B) and read (AR -> R) state machines.
module axi4_lite_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AWADDR,
  input  logic                           S_AWVALID,
  output logic                           S_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_WSTRB,
  input  logic                           S_WVALID,
  output logic                           S_WREADY,
  output logic [1:0]                     S_BRESP,
  output logic                           S_BVALID,
  input  logic                           S_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_ARADDR,
  input  logic                           S_ARVALID,
  output logic                           S_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_RDATA,
  output logic [1:0]                     S_RRESP,
  output logic                           S_RVALID,
  input  logic                           S_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_COLLECT, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wstate;
  rstate_t rstate;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> LSB) < ADDR_WIDTH'(NUM_REGS));
  endfunction

  function automatic logic [IDX_W-1:0] reg_index(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off[LSB +: IDX_W];
  endfunction

  assign S_AWREADY = ARESETN && (wstate == W_COLLECT) && !aw_held;
  assign S_WREADY  = ARESETN && (wstate == W_COLLECT) && !w_held;
  assign S_ARREADY = ARESETN && (rstate == R_IDLE);
  assign S_BVALID  = (wstate == W_RESP);
  assign S_BRESP   = bresp_q;
  assign S_RVALID  = (rstate == R_DATA);
  assign S_RDATA   = rdata_q;
  assign S_RRESP   = rresp_q;

  logic                  aw_fire, w_fire, ar_fire, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;

  assign aw_fire = S_AWVALID && S_AWREADY;
  assign w_fire  = S_WVALID && S_WREADY;
  assign ar_fire = S_ARVALID && S_ARREADY;
  // Commit when the later of the two handshakes lands (or both together).
  assign commit  = (wstate == W_COLLECT) && (aw_held || aw_fire) && (w_held || w_fire);
  assign wr_addr = aw_held ? aw_addr_q : S_AWADDR;
  assign wr_data = w_held ? w_data_q : S_WDATA;
  assign wr_strb = w_held ? w_strb_q : S_WSTRB;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wstate    <= W_COLLECT;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (wstate)
        W_COLLECT: begin
          if (aw_fire) begin
            aw_held   <= 1'b1;
            aw_addr_q <= S_AWADDR;
          end
          if (w_fire) begin
            w_held   <= 1'b1;
            w_data_q <= S_WDATA;
            w_strb_q <= S_WSTRB;
          end
          if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            wstate  <= W_RESP;
            if (in_range(wr_addr)) begin
              bresp_q <= RESP_OKAY;
              for (int b = 0; b < STRB_W; b++)
                if (wr_strb[b]) regs[reg_index(wr_addr)][b*8 +: 8] <= wr_data[b*8 +: 8];
            end else begin
              bresp_q <= RESP_SLVERR;
            end
          end
        end
        W_RESP: if (S_BREADY) wstate <= W_COLLECT;
        default: wstate <= W_COLLECT;
      endcase
    end
  end

  // Register bank is read with pre-edge values, so a same-edge commit is not visible.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rstate  <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: if (ar_fire) begin
          rstate <= R_DATA;
          if (in_range(S_ARADDR)) begin
            rdata_q <= regs[reg_index(S_ARADDR)];
            rresp_q <= RESP_OKAY;
          end else begin
            rdata_q <= '0;
            rresp_q <= RESP_SLVERR;
          end
        end
        R_DATA: if (S_RREADY) rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

endmodule

// File: doc/axi4_lite_reg_slave.md
# axi4_lite_reg_slave

Parametrised AXI4-Lite slave with an internal byte-addressable register bank, sitting on the processor's peripheral bus in place of the single-memory slave. Read and write channels run independently and concurrently; AW and W may arrive in any order or together. WSTRB byte enables, address range checking with OKAY/SLVERR responses, and a flat register view for fabric logic are all supported.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, data width; legal values are 32 and 64
- NUM_REGS, 32, register count; 1..256
- BASE_ADDR, 0, byte address of register 0; aligned to DATA_WIDTH/8

Ports (STRB_W = DATA_WIDTH/8):
- ACLK  in  1  clock
- ARESETN  in  1  reset, synchronous, active-low; clock ACLK
- S_AWADDR  in  ADDR_WIDTH  write address
- S_AWVALID  in  1  write address valid
- S_AWREADY  out  1  write address ready
- S_WDATA  in  DATA_WIDTH  write data
- S_WSTRB  in  STRB_W  byte enables
- S_WVALID  in  1  write data valid
- S_WREADY  out  1  write data ready
- S_BRESP  out  2  write response
- S_BVALID  out  1  write response valid
- S_BREADY  in  1  write response ready
- S_ARADDR  in  ADDR_WIDTH  read address
- S_ARVALID  in  1  read address valid
- S_ARREADY  out  1  read address ready
- S_RDATA  out  DATA_WIDTH  read data
- S_RRESP  out  2  read response
- S_RVALID  out  1  read data valid
- S_RREADY  in  1  read data ready
- regs_flat  out  NUM_REGS*DATA_WIDTH  live register contents; register i is at bits [i*DATA_WIDTH +: DATA_WIDTH]

## Operation
- Index = (addr − BASE_ADDR) >> log2(STRB_W). The low log2(STRB_W) address bits are ignored.
- An address is in range when addr ≥ BASE_ADDR and index < NUM_REGS. Otherwise the response is SLVERR (2'b10) and there is no side effect.
- Write path, states W_COLLECT and W_RESP:
  - W_COLLECT: AW and W are each captured into a holding register on their own handshake.
  - S_AWREADY = state==W_COLLECT && !aw_held. S_WREADY = state==W_COLLECT && !w_held.
  - Commit happens on the edge where the second of the two handshakes completes, or where both complete together.
  - On commit: for each byte b with WSTRB[b]=1, reg[index] byte b takes the WDATA byte. Bytes with WSTRB[b]=0 are unchanged.
  - On commit: BRESP = OKAY (2'b00) or SLVERR, holding flags clear, next state W_RESP.
  - W_RESP: S_BVALID=1, S_BRESP stable until the BREADY handshake, then back to W_COLLECT.
- Read path, states R_IDLE and R_DATA:
  - R_IDLE: S_ARREADY=1.
  - On the AR handshake, S_RDATA is registered from reg[index] (0 if out of range) and S_RRESP from the range check. Next state R_DATA.
  - R_DATA: S_RVALID=1. RDATA and RRESP are held stable until the RREADY handshake, then back to R_IDLE.
- Same-register collision: if a read is sampled on the same edge as a write commit, RDATA returns the pre-write value.
- regs_flat updates on the commit edge.
- All READY outputs are forced to 0 while ARESETN=0.

## Timing
- Reset, any cycle with ARESETN=0 at the edge:
  - All registers return to 0.
  - Both FSMs go idle and the holding flags clear.
  - S_BVALID=0, S_RVALID=0, S_BRESP=0, S_RRESP=0, S_RDATA=0.
  - Any in-flight transaction is dropped with no response.
- Write latency:
  - AW+W handshake at edge N → S_BVALID=1 from cycle N+1.
  - With BREADY held high, the BREADY handshake is at edge N+1 and AWREADY/WREADY return at N+2. Best case is one write per 2 cycles.
- AW at edge N, W at edge N+k: AWREADY is low from N+1 until the B handshake completes. Commit is at N+k.
- Read latency:
  - AR handshake at edge N → S_RVALID=1 from cycle N+1.
  - With RREADY high, S_ARREADY=1 again at N+2.
- RVALID/BVALID never drop without their READY. Back-pressure of any length is legal.
- The read and write FSMs never stall each other.

## Test plan
- Reset then read addr 0x0 → RVALID one cycle after AR, RDATA=0x0000_0000, RRESP=00.
- AW 0x8 and W 0xDEADBEEF, WSTRB=4'hF, in the same cycle → BVALID next cycle with BRESP=00. Then read 0x8 → 0xDEADBEEF, and regs_flat[95:64]=0xDEADBEEF.
- W 0x11223344 with WSTRB=4'b0101 three cycles before AW 0x8 → AWREADY stays high while WREADY drops after the W handshake. Read 0x8 → 0xDE22BE44.
- Write to 0x80 with NUM_REGS=32 → BRESP=10 and no register changes. Read 0x80 → RDATA=0, RRESP=10.
- Hold BREADY and RREADY low for 5 cycles during a concurrent write and read of reg 3. Requirements:
  - BVALID, RVALID and their data stay stable.
  - RDATA shows the old value if the AR handshake coincided with the commit edge.
  - No new AW or AR is accepted during the stall.
- Deassert ARESETN while BVALID=1 and RVALID=1 → both are 0 after the edge, all registers read 0 after reset, and the next write completes normally.
